// File: rtl/arb_defs.sv
// arb_defs: shared encodings and widths for the 8-way round-robin arbiter
package arb_defs;
  localparam int N_REQ = 8;
  localparam int IDX_W = 3;
  localparam int HOLD_W = 8;
  typedef enum logic {ST_IDLE = 1'b0, ST_GRANT = 1'b1} state_t;
endpackage

// File: rtl/rr_prio_enc8.sv
// rr_prio_enc8: rotating priority encoder, first set req bit at or after start wins
module rr_prio_enc8
  import arb_defs::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] start,
  output logic [IDX_W-1:0] idx,
  output logic [N_REQ-1:0] onehot,
  output logic             any
);
  logic [N_REQ-1:0] rot;
  logic [IDX_W-1:0] pos;
  assign rot = N_REQ'({req, req} >> start);
  always_comb begin
    pos = '0;
    for (int i = N_REQ - 1; i >= 0; i--) pos = rot[i] ? IDX_W'(i) : pos;
  end
  assign idx = pos + start;
  assign onehot = N_REQ'(1) << idx;
  assign any = |req;
endmodule

// File: rtl/rr_arbiter8.sv
// rr_arbiter8: round-robin arbiter with registered one-hot grant and hold timeout
module rr_arbiter8
  import arb_defs::*;
#(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid,
  output logic             timeout
);
  localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(MAX_HOLD);
  state_t st;
  logic [IDX_W-1:0] ptr, start, win_idx;
  logic [HOLD_W-1:0] hold_cnt;
  logic [N_REQ-1:0] win_oh;
  logic win_any, forced, release_now;
  // while granted, the search restarts just past the owner so it ends up last
  assign start = (st == ST_GRANT) ? gnt_idx + 1'b1 : ptr;
  assign forced = (MAX_HOLD != 0) && (hold_cnt == HOLD_LIM) && req[gnt_idx];
  assign release_now = !req[gnt_idx] || forced;
  rr_prio_enc8 u_enc (
    .req    (req),
    .start  (start),
    .idx    (win_idx),
    .onehot (win_oh),
    .any    (win_any)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      st        <= ST_IDLE;
      gnt       <= '0;
      gnt_idx   <= '0;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
      ptr       <= '0;
      hold_cnt  <= '0;
    end else begin
      timeout <= 1'b0;
      if (st == ST_IDLE || release_now) begin
        if (st == ST_GRANT) begin
          ptr     <= gnt_idx + 1'b1;
          timeout <= forced;
        end
        if (win_any) begin
          st        <= ST_GRANT;
          gnt       <= win_oh;
          gnt_idx   <= win_idx;
          gnt_valid <= 1'b1;
          hold_cnt  <= HOLD_W'(1);
        end else begin
          st        <= ST_IDLE;
          gnt       <= '0;
          gnt_valid <= 1'b0;
          hold_cnt  <= '0;
        end
      end else begin
        hold_cnt <= (&hold_cnt) ? hold_cnt : hold_cnt + 1'b1;
      end
    end
  end
endmodule
